imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request accept to response; legal range 1..15.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning word-address width, giving 2^ADDR_W 16-bit words.
REQ-003 SHALL use one clock; reset is asynchronous and active-low. Ports: clk and rst_n.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: req_valid  in  1  fetch requests an instruction.
REQ-007 Port: req_addr  in  16  byte address (PC).
REQ-008 Port: req_ready  out  1  responder can accept a request this cycle.
REQ-009 Port: flush  in  1  cancel the outstanding request (branch redirect).
REQ-010 Port: resp_valid  out  1  one-cycle pulse; resp_data is valid.
REQ-011 Port: resp_data  out  16  instruction word.
REQ-012 Port: resp_addr  out  16  req_addr of the request being answered.
REQ-013 Port: resp_err  out  1  answered address was out of range.
REQ-014 Port: ld_en  in  1  preload write strobe.
REQ-015 Port: ld_addr  in  ADDR_W  preload word address.
REQ-016 Port: ld_data  in  16  preload word.

Function
REQ-017 SHALL implement the states IDLE, WAIT and RESP.
REQ-018 req_ready SHALL be (state==IDLE or state==RESP) and not flush.
REQ-019 A request SHALL be accepted at a rising edge when req_valid and req_ready are both high.
- On accept, req_addr is latched.
- The word index is req_addr[ADDR_W:1]; bit 0 is ignored.
REQ-020 For a request accepted in cycle c, resp_valid SHALL be high in exactly cycle c+LATENCY and low in all other cycles.
REQ-021 Transitions after an accept:
- LATENCY=1: next state is RESP.
- LATENCY>1: next state is WAIT, with the 4-bit counter loaded with LATENCY-1.
- In WAIT, the counter decrements each cycle.
- WAIT moves to RESP in the cycle after the counter reaches 1.
REQ-022 In RESP, the next state SHALL be the accept state per REQ-021 if a request is accepted, otherwise IDLE; back-to-back throughput is one request per LATENCY cycles.
REQ-023 resp_data SHALL be read from the array in the RESP cycle at the latched index.
- A same-cycle ld_en write to that index is not visible; the old value is returned.
REQ-024 If any bit of latched addr[15:ADDR_W+1] is nonzero, the RESP cycle SHALL return resp_err=1 and resp_data=16'hF000 (HLT); otherwise resp_err=0.
REQ-025 resp_addr SHALL equal the latched address during RESP; resp_data, resp_addr and resp_err are don't-care when resp_valid=0.
REQ-026 When flush=1 in WAIT or RESP:
- resp_valid SHALL be forced 0 in that cycle.
- The next state SHALL be IDLE.
- No request is accepted in that cycle.
REQ-027 flush=1 in IDLE SHALL have no effect other than deasserting req_ready.
REQ-028 When ld_en=1, ld_data SHALL be written to array[ld_addr] at the rising edge, in any state.
REQ-029 req_valid while req_ready=0 SHALL be ignored; the requester holds or re-presents it.

Reset
REQ-030 While rst_n=0, the block SHALL immediately be in state IDLE with counter 0, resp_valid 0, resp_err 0, and resp_addr 0.
REQ-031 Reset asserted mid-WAIT or in RESP SHALL abort the request with no response after release.
REQ-032 Array contents SHALL NOT be affected by reset.
REQ-033 req_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-034 Single read: LATENCY=4, preload array[3]=16'hA1B2, request addr 0x0006 in cycle 0 -> resp_valid only in cycle 4, resp_data=A1B2, resp_addr=0x0006, resp_err=0.
REQ-035 Back-to-back reads:
- Stimulus: LATENCY=4, req_valid held high with addr 0x0000 then 0x0002.
- Response: accepts in cycles 0 and 4, responses in cycles 4 and 8, req_ready low in cycles 1-3.
REQ-036 Flush: request in cycle 0, flush in cycle 2 -> no resp_valid in cycles 0-10, req_ready=1 in cycle 3, new request in cycle 3 answered in cycle 7.
REQ-037 Out of range: ADDR_W=10, request addr 0x0800 -> resp_err=1, resp_data=0xF000.
REQ-038 Reset and preload:
- Reset: rst_n low in cycle 2 of a WAIT -> no response, outputs 0, and a new request after release is answered normally.
- Preload: LATENCY=1 with ld_en write to the same index in the response cycle -> old data returned.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, answers a fixed
// LATENCY cycles later from a preloadable 16-bit word array, flags addresses
// beyond the array as errors (returning HLT) and drops the request on flush.
module imem_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [15:0]       req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              resp_valid,
    output logic [15:0]       resp_data,
    output logic [15:0]       resp_addr,
    output logic              resp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [15:0] HLT_WORD = 16'hF000;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] mem_q [0:(1 << ADDR_W) - 1];
    logic        accept;
    logic        out_of_range;

    // Address bits above the word index must all be zero for an in-range fetch
    if (ADDR_W < 15) begin : g_range
        assign out_of_range = |addr_q[15:ADDR_W+1];
    end else begin : g_full
        assign out_of_range = 1'b0;
    end

    assign accept = req_valid && req_ready;

    // State, wait counter and latched request address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Preload port; the array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    // Next-state: accept from IDLE/RESP, count down in WAIT, flush aborts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = req_addr;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (accept) begin
                    addr_d = req_addr;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: read is combinational so a same-cycle preload write returns old data
    always_comb begin
        req_ready  = ((state_q == IDLE) || (state_q == RESP)) && !flush;
        resp_valid = (state_q == RESP) && !flush;
        resp_err   = (state_q == RESP) && out_of_range;
        resp_addr  = addr_q;
        resp_data  = out_of_range ? HLT_WORD : mem_q[addr_q[ADDR_W:1]];
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one LATENCY=4 instance for the main
// scenarios and one LATENCY=1 instance for the same-cycle preload case.
module tb_imem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        flush;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [15:0] ld_data;

    logic        req_ready4, resp_valid4, resp_err4;
    logic [15:0] resp_data4, resp_addr4;
    logic        req_ready1, resp_valid1, resp_err1;
    logic [15:0] resp_data1, resp_addr1;

    int checks   = 0;
    int failures = 0;

    imem_responder #(.LATENCY(4), .ADDR_W(10)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready4),
        .flush      (flush),
        .resp_valid (resp_valid4),
        .resp_data  (resp_data4),
        .resp_addr  (resp_addr4),
        .resp_err   (resp_err4),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
    );

    imem_responder #(.LATENCY(1), .ADDR_W(10)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready1),
        .flush      (flush),
        .resp_valid (resp_valid1),
        .resp_data  (resp_data1),
        .resp_addr  (resp_addr1),
        .resp_err   (resp_err1),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start of a cycle: just after the rising edge, where inputs are driven
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        tick();
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;

        // Reset state
        @(negedge clk);
        check("rst_valid", resp_valid4, 1'b0);
        check("rst_err",   resp_err4,   1'b0);
        check("rst_addr",  resp_addr4,  16'h0000);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", req_ready4, 1'b1);

        // Single read
        preload(10'd3, 16'hA1B2);
        tick();
        req_valid = 1'b1;
        req_addr  = 16'h0006;
        @(negedge clk);
        check("t1_ready_c0", req_ready4, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            tick();
            req_valid = 1'b0;
            @(negedge clk);
            check($sformatf("t1_valid_c%0d", c), resp_valid4, (c == 4));
            if (c == 4) begin
                check("t1_data", resp_data4, 16'hA1B2);
                check("t1_addr", resp_addr4, 16'h0006);
                check("t1_err",  resp_err4,  1'b0);
            end
        end

        // Back-to-back reads with req_valid held high
        preload(10'd0, 16'h1111);
        preload(10'd1, 16'h2222);
        tick();
        req_valid = 1'b1;
        req_addr  = 16'h0000;
        @(negedge clk);
        check("t2_ready_c0", req_ready4, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            tick();
            req_addr  = 16'h0002;
            req_valid = (c <= 4);
            @(negedge clk);
            check($sformatf("t2_valid_c%0d", c), resp_valid4, (c == 4) || (c == 8));
            if (c <= 3) check($sformatf("t2_ready_c%0d", c), req_ready4, 1'b0);
            if (c == 4) begin
                check("t2_ready_c4", req_ready4, 1'b1);
                check("t2_data0", resp_data4, 16'h1111);
                check("t2_addr0", resp_addr4, 16'h0000);
            end
            if (c == 8) begin
                check("t2_data1", resp_data4, 16'h2222);
                check("t2_addr1", resp_addr4, 16'h0002);
            end
        end

        // Flush in WAIT, then a fresh request right after
        preload(10'd5, 16'h5555);
        tick();
        req_valid = 1'b1;
        req_addr  = 16'h0004;
        for (int c = 1; c <= 10; c++) begin
            tick();
            req_valid = (c == 3);
            req_addr  = 16'h000A;
            flush     = (c == 2);
            @(negedge clk);
            check($sformatf("t3_valid_c%0d", c), resp_valid4, (c == 7));
            if (c == 3) check("t3_ready_c3", req_ready4, 1'b1);
            if (c == 7) check("t3_data", resp_data4, 16'h5555);
        end

        // Flush landing on the RESP cycle suppresses the response
        tick();
        req_valid = 1'b1;
        req_addr  = 16'h0006;
        for (int c = 1; c <= 8; c++) begin
            tick();
            req_valid = 1'b0;
            flush     = (c == 4);
            @(negedge clk);
            check($sformatf("t3r_valid_c%0d", c), resp_valid4, 1'b0);
            if (c == 4) check("t3r_ready_c4", req_ready4, 1'b0);
            if (c == 5) check("t3r_ready_c5", req_ready4, 1'b1);
        end

        // Flush in IDLE blocks acceptance
        tick();
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 16'h0006;
        @(negedge clk);
        check("t3i_ready", req_ready4, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            flush     = 1'b0;
            req_valid = 1'b0;
            @(negedge clk);
            check($sformatf("t3i_valid_c%0d", c), resp_valid4, 1'b0);
        end

        // Out-of-range address returns HLT with error
        tick();
        req_valid = 1'b1;
        req_addr  = 16'h0800;
        for (int c = 1; c <= 5; c++) begin
            tick();
            req_valid = 1'b0;
            @(negedge clk);
            check($sformatf("t4_valid_c%0d", c), resp_valid4, (c == 4));
            if (c == 4) begin
                check("t4_err",  resp_err4,  1'b1);
                check("t4_data", resp_data4, 16'hF000);
                check("t4_addr", resp_addr4, 16'h0800);
            end
        end

        // Reset during WAIT aborts the request
        tick();
        req_valid = 1'b1;
        req_addr  = 16'h0006;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_valid", resp_valid4, 1'b0);
        check("t5_rst_err",   resp_err4,   1'b0);
        check("t5_rst_addr",  resp_addr4,  16'h0000);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_rel_ready", req_ready4, 1'b1);
        for (int c = 4; c <= 8; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("t5_valid_c%0d", c), resp_valid4, 1'b0);
        end
        tick();
        req_valid = 1'b1;
        req_addr  = 16'h0006;
        for (int c = 1; c <= 5; c++) begin
            tick();
            req_valid = 1'b0;
            @(negedge clk);
            check($sformatf("t5n_valid_c%0d", c), resp_valid4, (c == 4));
            if (c == 4) check("t5n_data", resp_data4, 16'hA1B2);
        end

        // LATENCY=1: preload write in the response cycle returns old data
        preload(10'd7, 16'h7777);
        tick();
        req_valid = 1'b1;
        req_addr  = 16'h000E;
        @(negedge clk);
        check("t6_ready", req_ready1, 1'b1);
        tick();
        req_valid = 1'b0;
        ld_en     = 1'b1;
        ld_addr   = 10'd7;
        ld_data   = 16'h8888;
        @(negedge clk);
        check("t6_valid_c1", resp_valid1, 1'b1);
        check("t6_data_old", resp_data1,  16'h7777);
        check("t6_addr",     resp_addr1,  16'h000E);
        tick();
        ld_en     = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        check("t6_valid_c2", resp_valid1, 1'b0);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("t6_valid_c3", resp_valid1, 1'b1);
        check("t6_data_new", resp_data1,  16'h8888);
        tick();
        @(negedge clk);
        check("t6_valid_c4", resp_valid1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
